// File: rtl/ex_muldiv.sv
// HI/LO multiply/divide unit: single-cycle signed/unsigned multiply and a
// WORD_W-iteration restoring divider, with direct MTHI/MTLO writes and flush.
module ex_muldiv #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_start,
    input  logic [1:0]        ex_op,
    input  logic [WORD_W-1:0] ex_src1,
    input  logic [WORD_W-1:0] ex_src2,
    input  logic              ex_flush,
    input  logic              ex_whi,
    input  logic              ex_wlo,
    input  logic [WORD_W-1:0] ex_wdata,
    output logic              ex_stall,
    output logic              md_done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    localparam int CNT_W = $clog2(WORD_W) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        op_reg, op_next;
    logic [WORD_W-1:0] src1_reg, src1_next;
    logic [WORD_W-1:0] src2_reg, src2_next;
    logic [WORD_W-1:0] quot_reg, quot_next;
    logic [WORD_W-1:0] rem_reg, rem_next;
    logic [WORD_W-1:0] hi_reg, hi_next;
    logic [WORD_W-1:0] lo_reg, lo_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              md_done_reg, md_done_next;

    logic                start_ok;
    logic                is_signed;
    logic                src1_neg, src2_neg, in_neg;
    logic [WORD_W-1:0]   divisor_mag;
    logic [WORD_W-1:0]   dividend_in_mag;
    logic [2*WORD_W-1:0] mul_a, mul_b, product;
    logic [WORD_W:0]     rem_shift, diff;
    logic [WORD_W-1:0]   quot_fix, rem_fix;

    assign start_ok  = ex_start && !ex_flush;
    assign is_signed = ~op_reg[0];
    assign src1_neg  = is_signed & src1_reg[WORD_W-1];
    assign src2_neg  = is_signed & src2_reg[WORD_W-1];
    assign in_neg    = ~ex_op[0] & ex_src1[WORD_W-1];

    assign divisor_mag     = src2_neg ? -src2_reg : src2_reg;
    assign dividend_in_mag = in_neg ? -ex_src1 : ex_src1;

    // Sign-extending to full width lets one unsigned multiplier serve both
    // signed and unsigned products (low 2*WORD_W bits are identical).
    assign mul_a   = {{WORD_W{src1_neg}}, src1_reg};
    assign mul_b   = {{WORD_W{src2_neg}}, src2_reg};
    assign product = mul_a * mul_b;

    // One restoring step: quot_reg shifts the dividend out while collecting
    // quotient bits; diff[WORD_W] set means the trial subtraction borrowed.
    assign rem_shift = {rem_reg, quot_reg[WORD_W-1]};
    assign diff      = rem_shift - {1'b0, divisor_mag};

    assign quot_fix = (src1_neg ^ src2_neg) ? -quot_reg : quot_reg;
    assign rem_fix  = src1_neg ? -rem_reg : rem_reg;

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        src1_next    = src1_reg;
        src2_next    = src2_reg;
        quot_next    = quot_reg;
        rem_next     = rem_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        cnt_next     = cnt_reg;
        md_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ex_whi) hi_next = ex_wdata;
                if (ex_wlo) lo_next = ex_wdata;
                if (start_ok) begin
                    op_next    = ex_op;
                    src1_next  = ex_src1;
                    src2_next  = ex_src2;
                    quot_next  = dividend_in_mag;
                    rem_next   = '0;
                    cnt_next   = '0;
                    state_next = ex_op[1] ? DIV : MUL;
                end
            end
            MUL: begin
                {hi_next, lo_next} = product;
                md_done_next       = 1'b1;
                state_next         = IDLE;
            end
            DIV: begin
                if (!diff[WORD_W]) begin
                    rem_next  = diff[WORD_W-1:0];
                    quot_next = {quot_reg[WORD_W-2:0], 1'b1};
                end else begin
                    rem_next  = rem_shift[WORD_W-1:0];
                    quot_next = {quot_reg[WORD_W-2:0], 1'b0};
                end
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(WORD_W - 1)) state_next = FIX;
            end
            FIX: begin
                if (src2_reg == '0) begin
                    lo_next = '1;
                    hi_next = src1_reg;
                end else begin
                    lo_next = quot_fix;
                    hi_next = rem_fix;
                end
                md_done_next = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Flush wins over everything: abort and leave HI/LO untouched.
        if (ex_flush) begin
            state_next   = IDLE;
            hi_next      = hi_reg;
            lo_next      = lo_reg;
            md_done_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            op_reg      <= '0;
            src1_reg    <= '0;
            src2_reg    <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            cnt_reg     <= '0;
            md_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            src1_reg    <= src1_next;
            src2_reg    <= src2_next;
            quot_reg    <= quot_next;
            rem_reg     <= rem_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            cnt_reg     <= cnt_next;
            md_done_reg <= md_done_next;
        end
    end

    assign ex_stall = rst && ((state_reg != IDLE) || start_ok);
    assign md_done  = md_done_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule
